// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the single-precision float cores (squarer, adder,
// divider): IEEE-754 field widths, canonical constants, the squarer state
// encoding and the unpacked operand record.
// No ports.
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 23;
  localparam int          FP_BIAS = 127;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [3:0] {
    GET_A,
    UNPACK,
    SPECIAL,
    NORM_IN,
    MUL,
    NORM_OUT,
    ROUND,
    PACK,
    PUT_Z
  } fp_sq_state_t;

  // Operand after unpacking: true (unbiased) exponent kept signed and wide
  // enough for denormal normalisation, mantissa carries the hidden bit.
  typedef struct packed {
    logic               sign;
    logic signed [9:0]  exp;
    logic [MAN_W:0]     man;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_round_rne.sv
// -----------------------------------------------------------------------------
// fp_round_rne
// Combinational round-to-nearest-even for a 24-bit mantissa (hidden bit
// included) given the guard, round and sticky bits below it.
//
// Ports:
//   man          in  24  mantissa before rounding
//   guard        in   1  first bit below the mantissa LSB
//   round_bit    in   1  second bit below the mantissa LSB
//   sticky       in   1  OR of every remaining discarded bit
//   man_rounded  out 24  rounded mantissa (low 24 bits of the sum)
//   carry        out  1  rounding overflowed to 2^24; caller renormalises
// -----------------------------------------------------------------------------
module fp_round_rne (
  input  logic [23:0] man,
  input  logic        guard,
  input  logic        round_bit,
  input  logic        sticky,
  output logic [23:0] man_rounded,
  output logic        carry
);

  logic round_up;

  // Above half rounds up; exactly half (guard only) rounds to the even LSB.
  assign round_up = guard & (round_bit | sticky | man[0]);

  assign {carry, man_rounded} = {1'b0, man} + {24'd0, round_up};

endmodule

// File: rtl/fp_square.sv
// -----------------------------------------------------------------------------
// fp_square
// IEEE-754 single-precision squarer, z = a*a, round-to-nearest-even, behind
// the stb/ack single-operand handshake shared with the adder/divider cores.
//
// Ports:
//   clk           in   1  clock
//   rst           in   1  synchronous active-high reset, aborts any operation
//   input_a       in  32  operand
//   input_a_stb   in   1  operand valid
//   input_a_ack   out  1  ready; operand taken on an edge with stb & ack
//   output_z      out 32  result, stable while output_z_stb is high
//   output_z_stb  out  1  result valid
//   output_z_ack  in   1  consumer takes the result
//
// Build option:
//   SQUARE_DENORM_EN  when defined, denormal inputs are normalised and
//                     underflowing results become gradual-underflow denormals
//                     (variable latency). When undefined both flush to +0 and
//                     the accept-to-result latency is always 7 edges.
// -----------------------------------------------------------------------------
module fp_square
  import fp_pkg::*;
#(
  parameter logic [31:0] QNAN = FP_QNAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  // Special results skip NORM_IN, MUL, NORM_OUT and ROUND; PACK waits this
  // many cycles so every input class sees the same latency.
  localparam logic [2:0] SPECIAL_PAD = 3'd4;

  fp_sq_state_t      state;
  logic [31:0]       a_raw;
  fp_unpacked_t      a_u;

  logic signed [9:0] z_exp;
  logic [23:0]       z_man;
  logic              guard;
  logic              round_bit;
  logic              sticky;
  logic [47:0]       product;

  logic              is_special;
  logic [31:0]       z_special;
  logic [2:0]        pad;

`ifdef SQUARE_DENORM_EN
  // Set when rounding has been deferred until after the underflow shift.
  logic              rnd_pending;
  logic [23:0]       man_fin;
`endif

  logic [7:0]        a_exp_field;
  logic [MAN_W-1:0]  a_frac;
  logic [23:0]       man_rounded;
  logic              carry;
  logic signed [9:0] biased;
  logic              z_sign;
  logic [31:0]       z_packed;

  assign a_exp_field = a_raw[30:23];
  assign a_frac      = a_raw[MAN_W-1:0];

  fp_round_rne u_round (
    .man         (z_man),
    .guard       (guard),
    .round_bit   (round_bit),
    .sticky      (sticky),
    .man_rounded (man_rounded),
    .carry       (carry)
  );

  // Final encoding of a non-special result from the working registers.
  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    // Product sign is sa ^ sb; for a square both are the same bit.
    z_sign   = a_u.sign ^ a_u.sign;
    biased   = z_exp + 10'(FP_BIAS);
    z_packed = FP_ZERO;
`ifdef SQUARE_DENORM_EN
    man_fin  = rnd_pending ? man_rounded : z_man;
    if (biased >= 10'sd255)
      z_packed = FP_PINF;
    else if (!man_fin[23])
      // No hidden bit left after the underflow shift: denormal encoding.
      // A round-up into bit 23 lands on the smallest normal naturally.
      z_packed = {z_sign, 8'h00, man_fin[22:0]};
    else
      z_packed = {z_sign, biased[7:0], man_fin[22:0]};
`else
    if (biased >= 10'sd255)
      z_packed = FP_PINF;
    else if (biased <= 10'sd0)
      z_packed = FP_ZERO;
    else
      z_packed = {z_sign, biased[7:0], z_man[22:0]};
`endif
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register in this block samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control and the visible outputs are reset; the datapath
      // registers are always written before they are read, so resetting them
      // would add reset fan-out for no behavioural gain.
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= FP_ZERO;
    end else begin
      case (state)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a_raw       <= input_a;
            input_a_ack <= 1'b0;
            state       <= UNPACK;
          end else begin
            input_a_ack <= 1'b1;
          end
        end

        UNPACK: begin
          a_u.sign <= a_raw[31];
          if (a_exp_field == 8'h00) begin
            // Denormals share the exponent of the smallest normal.
            a_u.exp <= 10'sd1 - 10'(FP_BIAS);
            a_u.man <= {1'b0, a_frac};
          end else begin
            a_u.exp <= 10'(int'(a_exp_field)) - 10'(FP_BIAS);
            a_u.man <= {1'b1, a_frac};
          end
          state <= SPECIAL;
        end

        SPECIAL: begin
          is_special <= 1'b0;
          pad        <= SPECIAL_PAD;
          state      <= NORM_IN;
          if (a_exp_field == 8'hFF && a_frac != '0) begin
            is_special <= 1'b1;
            z_special  <= QNAN;
            state      <= PACK;
          end else if (a_exp_field == 8'hFF) begin
            is_special <= 1'b1;
            z_special  <= FP_PINF;
            state      <= PACK;
          end else if (a_exp_field == 8'h00 && a_frac == '0) begin
            is_special <= 1'b1;
            z_special  <= FP_ZERO;
            state      <= PACK;
          end
`ifndef SQUARE_DENORM_EN
          else if (a_exp_field == 8'h00) begin
            is_special <= 1'b1;
            z_special  <= FP_ZERO;
            state      <= PACK;
          end
`endif
        end

        NORM_IN: begin
`ifdef SQUARE_DENORM_EN
          if (!a_u.man[23]) begin
            a_u.man <= a_u.man << 1;
            a_u.exp <= a_u.exp - 10'sd1;
          end else begin
            state <= MUL;
          end
`else
          state <= MUL;
`endif
        end

        MUL: begin
          product <= 48'(a_u.man) * 48'(a_u.man);
          z_exp   <= a_u.exp + a_u.exp;
          state   <= NORM_OUT;
        end

        NORM_OUT: begin
          // Product of two 1.23 mantissas is 2.46; keep 24 significant bits
          // and fold the discarded bits into guard/round/sticky.
          if (product[47]) begin
            z_man     <= product[47:24];
            guard     <= product[23];
            round_bit <= product[22];
            sticky    <= |product[21:0];
            z_exp     <= z_exp + 10'sd1;
          end else begin
            z_man     <= product[46:23];
            guard     <= product[22];
            round_bit <= product[21];
            sticky    <= |product[20:0];
          end
          state <= ROUND;
        end

        ROUND: begin
`ifdef SQUARE_DENORM_EN
          // An underflowing result is rounded only after the denormal shift,
          // so it is rounded once at its final precision.
          rnd_pending <= (z_exp < -10'sd126);
          if (z_exp >= -10'sd126) begin
            z_man <= carry ? {1'b1, man_rounded[23:1]} : man_rounded;
            if (carry)
              z_exp <= z_exp + 10'sd1;
          end
`else
          z_man <= carry ? {1'b1, man_rounded[23:1]} : man_rounded;
          if (carry)
            z_exp <= z_exp + 10'sd1;
`endif
          state <= PACK;
        end

        PACK: begin
          if (is_special) begin
            if (pad != 3'd0) begin
              pad <= pad - 3'd1;
            end else begin
              output_z     <= z_special;
              output_z_stb <= 1'b1;
              state        <= PUT_Z;
            end
          end
`ifdef SQUARE_DENORM_EN
          // Shift toward the denormal range; once mantissa and guard are both
          // zero further shifts cannot change the rounded value, which bounds
          // this loop at 25 cycles.
          else if (z_exp < -10'sd126 && (z_man != '0 || guard)) begin
            z_man     <= z_man >> 1;
            guard     <= z_man[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
            z_exp     <= z_exp + 10'sd1;
          end
`endif
          else begin
            output_z     <= z_packed;
            output_z_stb <= 1'b1;
            state        <= PUT_Z;
          end
        end

        PUT_Z: begin
          if (output_z_ack) begin
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
            state        <= GET_A;
          end
        end

        default: begin
          state        <= GET_A;
          input_a_ack  <= 1'b0;
          output_z_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule
